axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, AXI byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, AXI data width; BYTES=DATA_W/8.
REQ-003 SHALL have parameter ID_W, default 4, AXI ID width; all IDs driven 0.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port ui_clk, input, 1, the single clock.
REQ-006 SHALL have port ui_clk_sync_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port init_calib_complete, input, 1, memory ready; gates command acceptance.
REQ-008 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_rw in 1 (1=write), cmd_addr in ADDR_W, cmd_len in 8 (beats-1).
REQ-009 SHALL have wr_valid in 1, wr_ready out 1, wr_data in DATA_W, wr_strb in BYTES: write stream.
REQ-010 SHALL have rd_valid out 1, rd_ready in 1, rd_data out DATA_W, rd_last out 1: read stream.
REQ-011 SHALL have done_valid out 1 (one-cycle pulse) and done_err out 1: completion status.
REQ-012 SHALL have AXI4 master ports aw*/w*/b*/ar*/r* (id, addr, len 8, size 3, burst 2, valid/ready, data, strb, last, resp 2) matching the MIG slave widths.

Function
REQ-013 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, ERR, with one transaction outstanding.
REQ-014 SHALL drive cmd_ready=1 only in IDLE while init_calib_complete=1; handshake = cmd_valid&cmd_ready.
REQ-015 SHALL register the command on handshake, forcing address bits [log2(BYTES)-1:0] to 0.
REQ-016 SHALL go to ERR instead of WR_ADDR/RD_ADDR when addr[11:0]+(len+1)*BYTES>4096, issuing no AXI traffic.
REQ-017 SHALL, in ERR, pulse done_valid=1 with done_err=1 for one cycle, then return to IDLE.
REQ-018 SHALL drive awlen/arlen=len, awsize/arsize=log2(BYTES), awburst/arburst=2'b01 (INCR).
REQ-019 SHALL hold awvalid/arvalid high with stable fields until awready/arready; entry to WR_DATA/RD_DATA follows on the next cycle.
REQ-020 SHALL, in WR_DATA, connect wvalid=wr_valid and wr_ready=wready combinationally, wdata/wstrb passed through; both 0 in other states.
REQ-021 SHALL count W handshakes with an 8-bit counter cleared at AW handshake; wlast=1 when count==len.
REQ-022 SHALL move to WR_RESP on the wlast handshake and hold bready=1 there; on bvalid, pulse done_valid with done_err=(bresp!=0), then IDLE.
REQ-023 SHALL, in RD_DATA, connect rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=rlast; rready=0 elsewhere.
REQ-024 SHALL sticky-flag an error on any beat with rresp!=0, rlast before count==len, or count==len without rlast.
REQ-025 SHALL terminate the read only on the rlast handshake, pulsing done_valid with done_err=sticky flag.
REQ-026 SHALL support len=0 (single beat, wlast on first beat) and len=255 without counter wrap.
REQ-027 SHALL ignore init_calib_complete deassertion mid-transaction; it blocks only the next command.
REQ-028 SHALL have zero-cycle pass-through latency on the W and R data paths (no buffering).

Reset
REQ-029 SHALL, on ui_clk_sync_rst=1 at a rising edge, enter IDLE and clear counter, sticky flag and registered command.
REQ-030 SHALL drive every output to 0 during reset, including cmd_ready, awvalid, arvalid, wvalid, bready, rready and done_valid.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation, with no reissue and no done pulse.

Structure
REQ-032 SHALL place the state enum and the constants BURST_INCR=2'b01, RESP_OKAY=2'b00 and BOUNDARY_4K=4096 in package axi_mst_pkg.
REQ-033 SHALL be a single module; no sub-module is required.

Verification
REQ-034 SHALL cover a write of len=3 at 0x1000 with an always-ready slave: 4 W beats, wlast on beat 4, bresp=0, one done_valid pulse with done_err=0.
REQ-035 SHALL cover a read of len=7 at 0x2000 with rd_ready toggling every cycle: 8 beats delivered in order, rd_last on beat 8, done_err=0.
REQ-036 SHALL cover a write at 0x0FE0 with len=1 and BYTES=32: no awvalid is ever asserted, and done_valid=done_err=1 occurs one cycle after the handshake.
REQ-037 SHALL cover a read where the slave asserts rlast at beat 3 of len=4: termination at beat 3 with done_err=1.
REQ-038 SHALL cover cmd_valid held high with init_calib_complete=0 for 100 cycles: cmd_ready stays 0, then the command is accepted one cycle after calibration rises.
REQ-039 SHALL cover reset asserted mid-WR_DATA: all valids are 0 after the next edge, no done pulse, and a new command is accepted cleanly.

Source files
------------

// File: rtl/axi_mst_pkg.sv
// Shared state encoding, AXI constants and the 4 KiB boundary helper for axi_burst_master.
package axi_mst_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StWrAddr = 3'd1;
    localparam state_t StWrData = 3'd2;
    localparam state_t StWrResp = 3'd3;
    localparam state_t StRdAddr = 3'd4;
    localparam state_t StRdData = 3'd5;
    localparam state_t StErr    = 3'd6;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam int unsigned BOUNDARY_4K = 4096;

    // 32-bit arithmetic so len=255 cannot wrap the beat count.
    function automatic logic crosses_4k(input logic [11:0] offs, input logic [7:0] len,
                                        input int unsigned bytes);
        int unsigned span;
        span = (int'(len) + 1) * bytes;
        return (int'(offs) + span) > BOUNDARY_4K;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master bridging a simple command/stream interface to MIG.
module axi_burst_master
    import axi_mst_pkg::*;
#(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ID_W   = 4
) (
    input  logic                  ui_clk,
    input  logic                  ui_clk_sync_rst,
    input  logic                  init_calib_complete,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  done_valid,
    output logic                  done_err,
    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ID_W-1:0]       arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFFS_W = $clog2(BYTES);

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    logic              cmd_hs, w_hs, r_hs, beat_err, at_last;
    logic [ADDR_W-1:0] addr_aligned;
    logic              unused_id;

    assign unused_id    = ^{bid, rid, rw_q};
    assign addr_aligned = cmd_addr & ~ADDR_W'(BYTES - 1);
    assign at_last      = (cnt_q == len_q);
    assign cmd_hs       = (state_q == StIdle) && init_calib_complete && cmd_valid;
    assign w_hs         = (state_q == StWrData) && wr_valid && wready;
    assign r_hs         = (state_q == StRdData) && rvalid && rd_ready;
    // A beat is bad if it errors or if rlast and the beat count disagree.
    assign beat_err     = (rresp != RESP_OKAY) || (rlast != at_last);

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    addr_d = addr_aligned;
                    len_d  = cmd_len;
                    rw_d   = cmd_rw;
                    cnt_d  = 8'd0;
                    err_d  = 1'b0;
                    if (crosses_4k(addr_aligned[11:0], cmd_len, BYTES)) begin
                        state_d = StErr;
                    end else begin
                        state_d = cmd_rw ? StWrAddr : StRdAddr;
                    end
                end
            end
            StWrAddr: begin
                if (awready) begin
                    cnt_d   = 8'd0;
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (w_hs) begin
                    if (at_last) state_d = StWrResp;
                    else         cnt_d   = cnt_q + 8'd1;
                end
            end
            StWrResp: begin
                if (bvalid) state_d = StIdle;
            end
            StRdAddr: begin
                if (arready) begin
                    cnt_d   = 8'd0;
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (r_hs) begin
                    err_d = err_q | beat_err;
                    if (rlast)               state_d = StIdle;
                    else if (cnt_q != 8'hFF) cnt_d   = cnt_q + 8'd1;
                end
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_q <= StIdle;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Every output is forced low while reset is asserted, even before the state register clears.
    always_comb begin
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        done_err   = 1'b0;
        awid       = '0;
        awaddr     = '0;
        awlen      = 8'd0;
        awsize     = 3'd0;
        awburst    = 2'b00;
        awvalid    = 1'b0;
        wdata      = '0;
        wstrb      = '0;
        wlast      = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        arid       = '0;
        araddr     = '0;
        arlen      = 8'd0;
        arsize     = 3'd0;
        arburst    = 2'b00;
        arvalid    = 1'b0;
        rready     = 1'b0;
        if (!ui_clk_sync_rst) begin
            awaddr  = addr_q;
            awlen   = len_q;
            awsize  = 3'(OFFS_W);
            awburst = BURST_INCR;
            araddr  = addr_q;
            arlen   = len_q;
            arsize  = 3'(OFFS_W);
            arburst = BURST_INCR;
            case (state_q)
                StIdle:   cmd_ready = init_calib_complete;
                StWrAddr: awvalid   = 1'b1;
                StWrData: begin
                    wvalid   = wr_valid;
                    wr_ready = wready;
                    wdata    = wr_data;
                    wstrb    = wr_strb;
                    wlast    = at_last;
                end
                StWrResp: begin
                    bready     = 1'b1;
                    done_valid = bvalid;
                    done_err   = bvalid && (bresp != RESP_OKAY);
                end
                StRdAddr: arvalid = 1'b1;
                StRdData: begin
                    rd_valid   = rvalid;
                    rready     = rd_ready;
                    rd_data    = rdata;
                    rd_last    = rlast;
                    done_valid = r_hs && rlast;
                    done_err   = r_hs && rlast && (err_q || beat_err);
                end
                StErr: begin
                    done_valid = 1'b1;
                    done_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: behavioural AXI slave plus write/read stream models.
module tb_axi_burst_master;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned BYTES  = DATA_W / 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic                ui_clk = 1'b0;
    logic                ui_clk_sync_rst, init_calib_complete;
    logic                cmd_valid, cmd_ready, cmd_rw;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [7:0]          cmd_len;
    logic                wr_valid, wr_ready;
    logic [DATA_W-1:0]   wr_data;
    logic [BYTES-1:0]    wr_strb;
    logic                rd_valid, rd_ready, rd_last;
    logic [DATA_W-1:0]   rd_data;
    logic                done_valid, done_err;
    logic [ID_W-1:0]     awid, bid, arid, rid;
    logic [ADDR_W-1:0]   awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [2:0]          awsize, arsize;
    logic [1:0]          awburst, arburst, bresp, rresp;
    logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [BYTES-1:0]    wstrb;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;
    int unsigned aw_cnt   = 0;

    beat_t             exp_w_q[$];
    beat_t             exp_r_q[$];
    logic [DATA_W-1:0] wsrc_q[$];
    logic              exp_done_q[$];

    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_len;
    int unsigned       cfg_r_beats = 1;
    int unsigned       cfg_r_seed  = 0;
    logic [1:0]        cfg_bresp   = 2'b00;
    logic              rd_toggle   = 1'b0;

    always #5 ui_clk = ~ui_clk;

    axi_burst_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_rw              (cmd_rw),
        .cmd_addr            (cmd_addr),
        .cmd_len             (cmd_len),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .wr_data             (wr_data),
        .wr_strb             (wr_strb),
        .rd_valid            (rd_valid),
        .rd_ready            (rd_ready),
        .rd_data             (rd_data),
        .rd_last             (rd_last),
        .done_valid          (done_valid),
        .done_err            (done_err),
        .awid                (awid),
        .awaddr              (awaddr),
        .awlen               (awlen),
        .awsize              (awsize),
        .awburst             (awburst),
        .awvalid             (awvalid),
        .awready             (awready),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .wlast               (wlast),
        .wvalid              (wvalid),
        .wready              (wready),
        .bid                 (bid),
        .bresp               (bresp),
        .bvalid              (bvalid),
        .bready              (bready),
        .arid                (arid),
        .araddr              (araddr),
        .arlen               (arlen),
        .arsize              (arsize),
        .arburst             (arburst),
        .arvalid             (arvalid),
        .arready             (arready),
        .rid                 (rid),
        .rdata               (rdata),
        .rresp               (rresp),
        .rlast               (rlast),
        .rvalid              (rvalid),
        .rready              (rready)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] pat(input int unsigned seed, input int unsigned i);
        logic [31:0] w;
        w = 32'h5A00_0000 ^ (seed << 12) ^ i;
        return {8{w}} ^ {{(DATA_W-32){1'b0}}, ~w};
    endfunction

    // Slave + stream models: sample handshakes at negedge, update drives just after posedge.
    initial begin : bfm
        logic w_hs, w_l, b_hs, ar_hs, r_hs, r_l, rd_hs, r_active;
        int unsigned r_idx;
        beat_t e;
        awready = 1'b1; arready = 1'b1; wready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00; bid = '0;
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
        rd_ready = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_strb = '1;
        r_active = 1'b0; r_idx = 0;
        forever begin
            @(negedge ui_clk);
            w_hs  = wvalid && wready;
            w_l   = wlast;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            r_l   = rlast;
            rd_hs = rd_valid && rd_ready;
            if (awvalid) aw_cnt++;
            if (awvalid && awready) begin
                check("awaddr", awaddr, exp_addr);
                check("awlen", awlen, exp_len);
                check("awsize", awsize, 3'd5);
                check("awburst", awburst, 2'b01);
            end
            if (ar_hs) begin
                check("araddr", araddr, exp_addr);
                check("arlen", arlen, exp_len);
                check("arsize", arsize, 3'd5);
                check("arburst", arburst, 2'b01);
            end
            if (w_hs) begin
                if (exp_w_q.size() == 0) check("w_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_w_q.pop_front();
                    check("wdata", wdata, e.data);
                    check("wlast", wlast, e.last);
                    check("wstrb", wstrb, {BYTES{1'b1}});
                end
            end
            if (rd_hs) begin
                if (exp_r_q.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_r_q.pop_front();
                    check("rd_data", rd_data, e.data);
                    check("rd_last", rd_last, e.last);
                end
            end
            if (done_valid) begin
                done_cnt++;
                if (exp_done_q.size() == 0) check("done_unexpected", 1'b1, 1'b0);
                else check("done_err", done_err, exp_done_q.pop_front());
            end
            @(posedge ui_clk);
            #1;
            if (ui_clk_sync_rst) begin
                bvalid = 1'b0;
                r_active = 1'b0;
                r_idx = 0;
            end else begin
                if (w_hs && wsrc_q.size() > 0) void'(wsrc_q.pop_front());
                if (w_hs && w_l) begin
                    bvalid = 1'b1;
                    bresp  = cfg_bresp;
                end
                if (b_hs) bvalid = 1'b0;
                if (ar_hs) begin
                    r_active = 1'b1;
                    r_idx = 0;
                end
                if (r_hs) begin
                    if (r_l) r_active = 1'b0;
                    else r_idx++;
                end
            end
            rvalid   = r_active;
            rdata    = pat(cfg_r_seed, r_idx);
            rlast    = r_active && (r_idx == cfg_r_beats - 1);
            rd_ready = rd_toggle ? !rd_ready : 1'b1;
            wr_valid = wsrc_q.size() > 0;
            wr_data  = wr_valid ? wsrc_q[0] : '0;
        end
    end

    task automatic load_w(input int unsigned seed, input int unsigned n, input logic mark_last);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.data = pat(seed, i);
            e.last = mark_last && (i == n - 1);
            wsrc_q.push_back(e.data);
            exp_w_q.push_back(e);
        end
    endtask

    task automatic load_r(input int unsigned seed, input int unsigned n);
        beat_t e;
        cfg_r_seed  = seed;
        cfg_r_beats = n;
        for (int i = 0; i < n; i++) begin
            e.data = pat(seed, i);
            e.last = (i == n - 1);
            exp_r_q.push_back(e);
        end
    endtask

    task automatic issue_cmd(input logic rw, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] len);
        int n;
        exp_addr = addr & ~ADDR_W'(BYTES - 1);
        exp_len  = len;
        @(posedge ui_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_len   = len;
        n = 0;
        @(negedge ui_clk);
        while (!cmd_ready && n < 500) begin
            @(negedge ui_clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 1'b0, 1'b1);
        @(posedge ui_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 3000) begin
            @(posedge ui_clk);
            n++;
        end
        if (done_cnt == start) check({tag, "_timeout"}, 1'b0, 1'b1);
        @(negedge ui_clk);
        check({tag, "_pulse_one_cycle"}, done_valid, 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int unsigned aw_before, done_before, ready_seen;
        ui_clk_sync_rst = 1'b1;
        init_calib_complete = 1'b1;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
        exp_addr = '0; exp_len = 8'd0;

        // Reset: outputs low even with calibration done.
        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_valids", {awvalid, arvalid, wvalid, bready, rready, done_valid}, 6'b0);
        @(posedge ui_clk);
        #1;
        ui_clk_sync_rst = 1'b0;
        @(negedge ui_clk);
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Write len=3 at 0x1000.
        load_w(1, 4, 1'b1);
        exp_done_q.push_back(1'b0);
        issue_cmd(1'b1, 28'h000_1000, 8'd3);
        wait_done("wr_len3");
        check("wr_len3_drained", exp_w_q.size(), 0);

        // Read len=7 at 0x2000 with rd_ready toggling.
        rd_toggle = 1'b1;
        load_r(2, 8);
        exp_done_q.push_back(1'b0);
        issue_cmd(1'b0, 28'h000_2000, 8'd7);
        wait_done("rd_len7");
        check("rd_len7_drained", exp_r_q.size(), 0);
        rd_toggle = 1'b0;

        // 4 KiB crossing: no AW, error done one cycle after handshake.
        aw_before = aw_cnt;
        exp_done_q.push_back(1'b1);
        issue_cmd(1'b1, 28'h000_0FE0, 8'd1);
        @(negedge ui_clk);
        check("err_done_latency", {done_valid, done_err}, 2'b11);
        repeat (4) @(posedge ui_clk);
        check("err_no_awvalid", aw_cnt, aw_before);

        // len=255 always crosses with 32-byte beats; must not wrap to a legal length.
        aw_before = aw_cnt;
        exp_done_q.push_back(1'b1);
        issue_cmd(1'b1, 28'h000_8000, 8'd255);
        wait_done("len255_err");
        check("len255_no_awvalid", aw_cnt, aw_before);

        // Ending exactly at the boundary is legal; unaligned low bits are dropped.
        load_w(3, 2, 1'b1);
        exp_done_q.push_back(1'b0);
        issue_cmd(1'b1, 28'h000_0FC7, 8'd1);
        wait_done("wr_at_4k_edge");

        // Read with rlast at beat 3 of a 5-beat burst.
        load_r(4, 3);
        exp_done_q.push_back(1'b1);
        issue_cmd(1'b0, 28'h000_3000, 8'd4);
        wait_done("rd_early_last");
        check("rd_early_drained", exp_r_q.size(), 0);

        // Error B response; calibration dropping mid-flight must not stall completion.
        cfg_bresp = 2'b10;
        load_w(5, 2, 1'b1);
        exp_done_q.push_back(1'b1);
        issue_cmd(1'b1, 28'h000_9000, 8'd1);
        init_calib_complete = 1'b0;
        wait_done("wr_bresp_err");
        cfg_bresp = 2'b00;

        // Calibration low blocks a held command for 100 cycles.
        load_r(6, 1);
        exp_done_q.push_back(1'b0);
        exp_addr = 28'h000_4000;
        exp_len  = 8'd0;
        @(posedge ui_clk);
        #1;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 28'h000_4000; cmd_len = 8'd0;
        ready_seen = 0;
        repeat (100) begin
            @(negedge ui_clk);
            if (cmd_ready) ready_seen++;
        end
        check("calib_blocks", ready_seen, 0);
        @(posedge ui_clk);
        #1;
        init_calib_complete = 1'b1;
        @(negedge ui_clk);
        check("calib_ready_rises", cmd_ready, 1'b1);
        @(posedge ui_clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge ui_clk);
        check("calib_accepted_arvalid", arvalid, 1'b1);
        wait_done("rd_len0");

        // Reset while stalled in WR_DATA.
        load_w(7, 3, 1'b0);
        issue_cmd(1'b1, 28'h000_5000, 8'd7);
        for (int n = 0; n < 200 && exp_w_q.size() != 0; n++) @(posedge ui_clk);
        check("midrst_beats_sent", exp_w_q.size(), 0);
        repeat (2) @(posedge ui_clk);
        done_before = done_cnt;
        #1;
        ui_clk_sync_rst = 1'b1;
        @(negedge ui_clk);
        check("midrst_outputs_in_rst", {wvalid, wr_ready, awvalid, arvalid, bready, cmd_ready},
              6'b0);
        @(posedge ui_clk);
        #1;
        check("midrst_valids_after_edge", {awvalid, arvalid, wvalid, bready, rready, done_valid},
              6'b0);
        ui_clk_sync_rst = 1'b0;
        wsrc_q.delete();
        repeat (5) @(posedge ui_clk);
        check("midrst_no_done", done_cnt, done_before);
        load_w(8, 1, 1'b1);
        exp_done_q.push_back(1'b0);
        issue_cmd(1'b1, 28'h000_6000, 8'd0);
        wait_done("post_rst_wr");
        check("post_rst_drained", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
